// File: rtl/led_blinker.sv
// led_blinker: plays a command of N short or long LED blinks, each followed
// by a dark gap, and reports completion with a one-cycle done pulse.
// All phase timing is counted in ticks of a TICK_DIV-cycle prescaler that
// restarts whenever a phase is entered.
// Optional feature macro: LED_BLINKER_FIFO_EN -- when defined, up to two
// commands may be outstanding (one running, one waiting); when undefined
// only one command is held at a time.

`default_nettype none

module led_blinker #(
   parameter int unsigned TICK_DIV = 50000,  // clock cycles per tick
   parameter int unsigned SHORT_ON = 200,    // ticks lit, short blink
   parameter int unsigned LONG_ON  = 800,    // ticks lit, long blink
   parameter int unsigned GAP      = 200,    // ticks dark after a blink
   parameter logic        ON_STATE = 1'b1    // pin level that lights the LED
) (
   input  logic       clk,
   input  logic       arst,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [3:0] cmd_count_i,
   input  logic       cmd_long_i,
   output logic       led_o,
   output logic       busy_o,
   output logic       done_o
);

   // Counter sizing: the prescaler reaches TICK_DIV-1, the phase counter
   // reaches the longest phase length minus one.
   localparam int unsigned ON_MAX    = (LONG_ON > SHORT_ON) ? LONG_ON : SHORT_ON;
   localparam int unsigned PHASE_MAX = (ON_MAX > GAP) ? ON_MAX : GAP;
   localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW        = (PHASE_MAX > 1) ? $clog2(PHASE_MAX) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_ON - 1);
   localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_ON - 1);
   localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [CW-1:0] phase_q, phase_d;
   logic [3:0]    rem_q, rem_d;      // blinks still to finish, current included
   logic          long_q, long_d;
   logic          led_q, led_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          ready_q, ready_d;
   logic [1:0]    outst_q, outst_d;  // accepted commands not yet completed

   logic          accept;
   logic          src_valid;         // a command is available to start
   logic [3:0]    src_count;
   logic          src_long;
   logic          tick;
   logic          phase_end;
   logic [CW-1:0] phase_last;

   assign accept = cmd_valid_i & ready_q;

`ifdef LED_BLINKER_FIFO_EN
   // Two-entry queue of waiting commands, stored as {long, count}.
   logic [4:0] q_mem [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] fcnt_q, fcnt_d;
   logic       q_nonempty;
   logic       start_go;
   logic       q_push;
   logic       q_pop;
   logic [4:0] q_head;

   assign q_nonempty = (fcnt_q != 2'd0);
   assign q_head     = q_mem[rd_ptr_q];
   assign start_go   = (state_q == IDLE) && src_valid;

   // Command source: a waiting command has priority; an idle FSM with an
   // empty queue starts straight from the handshake without queueing.
   always_comb begin
      src_valid = q_nonempty | accept;
      src_count = q_nonempty ? q_head[3:0] : cmd_count_i;
      src_long  = q_nonempty ? q_head[4]   : cmd_long_i;
      q_pop     = start_go & q_nonempty;
      q_push    = accept & ~(start_go & ~q_nonempty);
      wr_ptr_d  = q_push ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d  = q_pop  ? ~rd_ptr_q : rd_ptr_q;
      fcnt_d    = fcnt_q + {1'b0, q_push} - {1'b0, q_pop};
   end

   // Queue storage write; contents need no reset since occupancy gates reads.
   always_ff @(posedge clk) begin
      if (q_push) begin
         q_mem[wr_ptr_q] <= {cmd_long_i, cmd_count_i};
      end
   end

   // Queue pointer and occupancy registers.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         fcnt_q   <= 2'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fcnt_q   <= fcnt_d;
      end
   end
`else
   // Without a queue the only command source is the handshake itself;
   // ready is only high in IDLE so an acceptance always finds the FSM idle.
   always_comb begin
      src_valid = accept;
      src_count = cmd_count_i;
      src_long  = cmd_long_i;
   end
`endif

   // FSM next state, phase timing and blink bookkeeping.
   always_comb begin
      state_d    = state_q;
      presc_d    = presc_q;
      phase_d    = phase_q;
      rem_d      = rem_q;
      long_d     = long_q;
      done_d     = 1'b0;
      phase_last = GAP_LAST;
      if (state_q == ON) begin
         phase_last = long_q ? LONG_LAST : SHORT_LAST;
      end
      tick      = (presc_q == PRESC_LAST);
      phase_end = tick && (phase_q == phase_last);

      case (state_q)
         IDLE: begin
            if (src_valid && (state_q == IDLE)) begin
               if (src_count == 4'd0) begin
                  // Empty command: finish at once, LED untouched.
                  done_d = 1'b1;
               end else begin
                  state_d = ON;
                  rem_d   = src_count;
                  long_d  = src_long;
                  presc_d = '0;
                  phase_d = '0;
               end
            end
         end
         ON, OFF: begin
            if (tick) begin
               presc_d = '0;
            end else begin
               presc_d = presc_q + PW'(1);
            end
            if (tick && !phase_end) begin
               phase_d = phase_q + CW'(1);
            end
            if (phase_end) begin
               // Every phase entry restarts both counters.
               presc_d = '0;
               phase_d = '0;
               if (state_q == ON) begin
                  state_d = OFF;
               end else if (rem_q > 4'd1) begin
                  rem_d   = rem_q - 4'd1;
                  state_d = ON;
               end else begin
                  rem_d   = 4'd0;
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake, busy and LED drive, all derived from the next state so the
   // registered outputs line up with the state they describe.
   always_comb begin
      outst_d = outst_q + {1'b0, accept} - {1'b0, done_d};
      busy_d  = (outst_d != 2'd0) || done_d;
      led_d   = (state_d == ON) ? ON_STATE : ~ON_STATE;
`ifdef LED_BLINKER_FIFO_EN
      ready_d = (outst_d != 2'd2);
`else
      ready_d = (state_d == IDLE) && !done_d;
`endif
   end

   // State and output registers; reset aborts any command silently.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= IDLE;
         presc_q <= '0;
         phase_q <= '0;
         rem_q   <= 4'd0;
         long_q  <= 1'b0;
         led_q   <= ~ON_STATE;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         outst_q <= 2'd0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         phase_q <= phase_d;
         rem_q   <= rem_d;
         long_q  <= long_d;
         led_q   <= led_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         outst_q <= outst_d;
      end
   end

   assign cmd_ready_o = ready_q;
   assign led_o       = led_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

`default_nettype wire
